// File: rtl/alu_result_fifo.sv
// ---------------------------------------------------------------------------
// alu_result_fifo
// Capture stage behind the 4-bit ALU. Each valid ALU output is stored
// together with its opcode and carry flag in a small first-word-fall-through
// FIFO. The consumer reads the FIFO over a valid/ready handshake. A sticky
// overflow flag and a saturating carry-event counter are kept for status.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-high reset
//   clr_i          synchronous clear of overflow_o and carry_cnt_o only
//   in_valid_i     ALU output is valid this cycle (capture strobe)
//   in_code_i      opcode that produced in_result_i
//   in_result_i    ALU result
//   in_flag_c_i    ALU carry/borrow flag
//   in_ready_o     FIFO not full
//   out_valid_o    FIFO not empty
//   out_ready_i    consumer accepts the head entry
//   out_code_o     head opcode (0 when empty)
//   out_result_o   head result (0 when empty)
//   out_flag_c_o   head carry flag (0 when empty)
//   level_o        number of stored entries, 0..DEPTH
//   overflow_o     sticky, set when a capture is dropped
//   carry_cnt_o    accepted entries with carry set, saturates at 255
// ---------------------------------------------------------------------------
module alu_result_fifo #(
  parameter int DEPTH  = 4,
  parameter int RES_W  = 8,
  parameter int CODE_W = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       in_valid_i,
  input  logic [CODE_W-1:0]          in_code_i,
  input  logic [RES_W-1:0]           in_result_i,
  input  logic                       in_flag_c_i,
  output logic                       in_ready_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [CODE_W-1:0]          out_code_o,
  output logic [RES_W-1:0]           out_result_o,
  output logic                       out_flag_c_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o,
  output logic [7:0]                 carry_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = CODE_W + RES_W + 1;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       carry_cnt_q, carry_cnt_d;

  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic             drop_s;
  logic [ENT_W-1:0] head_s;

  // Full/empty come from the occupancy count, never from pointer equality.
  assign full_s  = (level_q == LVL_W'(DEPTH));
  assign empty_s = (level_q == {LVL_W{1'b0}});

  // The ALU cannot be stalled: a capture while full is lost, even if the
  // consumer pops on the same edge.
  assign push_s = in_valid_i && !full_s;
  assign pop_s  = out_ready_i && !empty_s;
  assign drop_s = in_valid_i && full_s;

  // Next-state computation for pointers, level and status registers.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    carry_cnt_d = carry_cnt_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // A drop on the same edge as clr must still be reported.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clr_i) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    // clr dominates a coincident increment.
    if (clr_i) begin
      carry_cnt_d = 8'd0;
    end else if (push_s && in_flag_c_i && (carry_cnt_q != 8'hFF)) begin
      carry_cnt_d = carry_cnt_q + 8'd1;
    end else begin
      carry_cnt_d = carry_cnt_q;
    end
  end

  // Control and status state with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      level_q     <= {LVL_W{1'b0}};
      overflow_q  <= 1'b0;
      carry_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      carry_cnt_q <= carry_cnt_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {in_code_i, in_result_i, in_flag_c_i};
    end
  end

  // Fall-through head, forced to zero while the FIFO is empty.
  always_comb begin
    head_s = {ENT_W{1'b0}};
    if (!empty_s) begin
      head_s = mem_q[rd_ptr_q];
    end else begin
      head_s = {ENT_W{1'b0}};
    end
  end

  assign in_ready_o   = !full_s;
  assign out_valid_o  = !empty_s;
  assign out_code_o   = head_s[ENT_W-1 -: CODE_W];
  assign out_result_o = head_s[RES_W:1];
  assign out_flag_c_o = head_s[0];
  assign level_o      = level_q;
  assign overflow_o   = overflow_q;
  assign carry_cnt_o  = carry_cnt_q;

endmodule
